inst_mem_burst_ctrl: RTL
========================

# inst_mem_burst_ctrl

Memory-side responder for the instruction cache's block-fill protocol. It accepts a held `mem_req_op`/`mem_addr` request and reads one aligned block of `2^BLOCK_OFFSET_WIDTH` words from a synchronous BRAM. It then streams the words back in order on `mem_read`/`mem_read_valid` and flags the final word with `mem_last`. It sits between the L1 instruction cache and the instruction BRAM.

## Interface
- `DATA_WIDTH`, 32, word width.
- `ADDR_WIDTH`, 16, word address width; one word per address.
- `BLOCK_OFFSET_WIDTH`, 5, log2 of words per block; the block is 32 words.
- `READ_LATENCY`, 1, BRAM cycles from `bram_en` to valid `bram_dout`; legal range 1..4.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_addr`  in  ADDR_WIDTH  block address from the cache; low offset bits are ignored.
- `mem_req_op`  in  1  request; the cache holds it high for the whole fill.
- `mem_read`  out  DATA_WIDTH  returned word; 0 when `mem_read_valid`=0.
- `mem_read_valid`  out  1  `mem_read` carries a word this cycle.
- `mem_last`  out  1  final word of the block; only asserted together with `mem_read_valid`.
- `bram_en`  out  1  BRAM read enable.
- `bram_addr`  out  ADDR_WIDTH  BRAM read address.
- `bram_dout`  in  DATA_WIDTH  BRAM read data.
- `busy`  out  1  state != IDLE.

## Operation
- States: IDLE, ISSUE, DRAIN, RELEASE.
- IDLE, `mem_req_op`=1:
  - capture `base = {mem_addr[ADDR_WIDTH-1:BLOCK_OFFSET_WIDTH], 0}`;
  - clear `issue_cnt`;
  - go to ISSUE.
- ISSUE:
  - `bram_en`=1, `bram_addr = base | issue_cnt`, `issue_cnt`+1 every cycle;
  - after issuing offset `BLOCK_SIZE-1`, go to DRAIN.
- Offset arithmetic uses `BLOCK_OFFSET_WIDTH` bits, so addresses never carry into the tag/index bits. Block 0xFFE0 reads 0xFFE0..0xFFFF with no wrap to 0.
- Read pipeline: a `READ_LATENCY`-deep shift register of {valid, last} bits is pushed once per issued read. `last` is set for offset `BLOCK_SIZE-1`.
  - `mem_read_valid` = pipe tail valid.
  - `mem_last` = pipe tail last.
  - `mem_read` = `bram_dout` gated by `mem_read_valid`.
- DRAIN: stays until the cycle `mem_last`=1, then goes to RELEASE.
- RELEASE: waits for `mem_req_op`=0, then returns to IDLE. This prevents re-triggering on a request still held from the finished fill.
- Abort: `mem_req_op`=0 in ISSUE or DRAIN:
  - stop issuing and flush the pipe (no further valid/last);
  - go to IDLE.
- `mem_addr` changes after capture are ignored.
- Reset (any time, including mid-burst):
  - state IDLE, pipe cleared, `issue_cnt`=0;
  - all outputs 0;
  - no partial stream continues after release.

## Timing
- Request sampled in IDLE at cycle 0.
- First `bram_en` at cycle 1.
- Word k valid at cycle `1+READ_LATENCY+k`.
- `mem_last` at `T = BLOCK_SIZE+READ_LATENCY` (33 with defaults).
- Words are delivered on consecutive cycles with no gaps.
- Turnaround:
  - RELEASE at T+1; if `mem_req_op`=0 at T+1, IDLE at T+2.
  - A new request is accepted at T+2 at the earliest.
  - This matches the cache's READY→MISS minimum, with the new request high at T+2.
- `mem_read_valid` never asserts in IDLE or RELEASE, or in ISSUE before `READ_LATENCY` cycles have elapsed.

## Test plan
- Reset then `mem_addr`=0x0123, req held, BRAM[a]=a·3 → words 0x0120·3..0x013F·3 on cycles 2..33, `mem_last` only at cycle 33, `busy` falls at cycle 35 after req drops at 34.
- `READ_LATENCY`=3, `mem_addr`=0xFFE7 → `bram_addr` 0xFFE0..0xFFFF, first valid at cycle 4, last at cycle 35, no address carry.
- Back-to-back: req drops the cycle after last and rises one cycle later with 0x0040 → second burst starts `bram_en` the cycle after acceptance; there is no duplicate burst of the first block.
- Req held high 5 cycles past `mem_last` → stays in RELEASE, `bram_en`=0, no valid; returns to IDLE one cycle after req drops.
- Req dropped at cycle 10 of a burst → `mem_read_valid`=0 from cycle 11 onward, IDLE at cycle 11, `mem_last` never asserted.
- `rst_n` pulsed low at cycle 15 mid-burst → all outputs 0 immediately, state IDLE; after release, a new request at 0x0200 streams a full 32-word block correctly.

Source files
------------

// File: rtl/inst_mem_burst_ctrl_if.sv
// Cache-side block-fill bus between the L1 instruction cache (master)
// and the instruction memory burst responder (slave).
interface inst_mem_burst_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_req_op;
  logic [DATA_WIDTH-1:0] mem_read;
  logic                  mem_read_valid;
  logic                  mem_last;

  modport master (
    output mem_addr, mem_req_op,
    input  mem_read, mem_read_valid, mem_last
  );

  modport slave (
    input  mem_addr, mem_req_op,
    output mem_read, mem_read_valid, mem_last
  );
endinterface

// File: rtl/inst_mem_burst_ctrl.sv
// Instruction memory burst responder: reads one aligned block from a
// synchronous BRAM and streams it back word by word, flagging the last word.
module inst_mem_burst_ctrl #(
  parameter int unsigned DATA_WIDTH         = 32,
  parameter int unsigned ADDR_WIDTH         = 16,
  parameter int unsigned BLOCK_OFFSET_WIDTH = 5,
  parameter int unsigned READ_LATENCY       = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  inst_mem_burst_ctrl_if.slave    mem,
  output logic                    bram_en,
  output logic [ADDR_WIDTH-1:0]   bram_addr,
  input  logic [DATA_WIDTH-1:0]   bram_dout,
  output logic                    busy
);

  localparam int unsigned BLOCK_SIZE = 1 << BLOCK_OFFSET_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'(BLOCK_SIZE - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RELEASE} state_t;

  state_t                        state, state_next;
  logic [ADDR_WIDTH-1:0]         base;
  logic [BLOCK_OFFSET_WIDTH-1:0] issue_cnt;
  logic [READ_LATENCY-1:0]       valid_pipe, last_pipe;
  logic                          issue_done, accept, abort, tail_valid, tail_last;

  assign issue_done = (issue_cnt == '1);
  assign accept     = (state == IDLE) && mem.mem_req_op;
  assign abort      = ((state == ISSUE) || (state == DRAIN)) && !mem.mem_req_op;
  assign tail_valid = valid_pipe[READ_LATENCY-1];
  assign tail_last  = last_pipe[READ_LATENCY-1] && tail_valid;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; a dropped request aborts the fill from ISSUE or DRAIN
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (mem.mem_req_op) state_next = ISSUE;
      ISSUE:   if (!mem.mem_req_op) state_next = IDLE;
               else if (issue_done) state_next = DRAIN;
      DRAIN:   if (!mem.mem_req_op) state_next = IDLE;
               else if (tail_last) state_next = RELEASE;
      RELEASE: if (!mem.mem_req_op) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Block base capture, issue counter and {valid,last} read pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base       <= '0;
      issue_cnt  <= '0;
      valid_pipe <= '0;
      last_pipe  <= '0;
    end else begin
      if (accept) begin
        base      <= mem.mem_addr & ~OFFSET_MASK;
        issue_cnt <= '0;
      end else if (state == ISSUE) begin
        issue_cnt <= issue_cnt + BLOCK_OFFSET_WIDTH'(1);
      end

      if (abort) begin
        valid_pipe <= '0;
        last_pipe  <= '0;
      end else begin
        valid_pipe <= (valid_pipe << 1) | READ_LATENCY'(state == ISSUE);
        last_pipe  <= (last_pipe << 1)  | READ_LATENCY'((state == ISSUE) && issue_done);
      end
    end
  end

  // Output decode; offset is OR-ed into a masked base so it never carries
  always_comb begin
    bram_en            = 1'b0;
    bram_addr          = '0;
    busy               = (state != IDLE);
    mem.mem_read_valid = tail_valid;
    mem.mem_last       = tail_last;
    mem.mem_read       = tail_valid ? bram_dout : '0;
    if (state == ISSUE) begin
      bram_en   = 1'b1;
      bram_addr = base | ADDR_WIDTH'(issue_cnt);
    end
  end

endmodule
